// File: rtl/wts_pkg.sv
// Shared widths, FSM encoding and SRAM request layout for the wavetable mixer.
package wts_pkg;

  localparam int unsigned WTS_SAMPLE_W     = 8;
  localparam int unsigned WTS_ENV_W        = 9;
  localparam int unsigned WTS_ADDR_W       = 7;
  localparam int unsigned WTS_MIX_W        = 14;
  localparam int unsigned WTS_ENV_SHIFT    = 8;
  localparam int unsigned WTS_SLOT_W       = 3;
  localparam int unsigned WTS_PROD_W       = 17;
  localparam int unsigned WTS_SCALED_W     = 10;
  localparam int unsigned WTS_DRAIN_CYCLES = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SNAP  = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } wts_state_e;

  typedef struct packed {
    logic [WTS_SLOT_W-1:0] slot;
    logic [WTS_ADDR_W-1:0] addr;
  } wts_sram_req_t;

endpackage

// File: rtl/wts_channel_mac.sv
// Per-slot sample pipeline: capture, signed x unsigned scale, enable gate, accumulate.
module wts_channel_mac
  import wts_pkg::*;
(
  input  logic                           clk,
  input  logic                           nreset,
  input  logic                           clear,
  input  logic                           valid,
  input  logic [WTS_ENV_W-1:0]           env,
  input  logic                           en,
  input  logic signed [WTS_SAMPLE_W-1:0] sram_q,
  output logic signed [WTS_MIX_W-1:0]    acc_c
);

  logic                           v1_q, v2_q, v3_q;
  logic [WTS_ENV_W-1:0]           env1_q, env2_q;
  logic                           en1_q, en2_q;
  logic signed [WTS_SAMPLE_W-1:0] q_q;
  logic signed [WTS_PROD_W-1:0]   prod_q;
  logic signed [WTS_PROD_W-1:0]   prod_c;
  logic signed [WTS_SCALED_W-1:0] scaled_c;
  logic signed [WTS_MIX_W-1:0]    contrib_c;
  logic signed [WTS_MIX_W-1:0]    acc_q;

  // Envelope is zero-extended so the multiply stays signed; the product always fits 17 bits.
  always_comb begin
    prod_c    = WTS_PROD_W'(q_q) * WTS_PROD_W'($signed({1'b0, env2_q}));
    scaled_c  = WTS_SCALED_W'(prod_q >>> WTS_ENV_SHIFT);
    contrib_c = v3_q ? WTS_MIX_W'(scaled_c) : '0;
    acc_c     = acc_q + contrib_c;
  end

  // Clear also flushes in-flight reads so an aborted frame cannot leak into the next one.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      env1_q <= '0;
      env2_q <= '0;
      en1_q  <= 1'b0;
      en2_q  <= 1'b0;
      q_q    <= '0;
      prod_q <= '0;
      acc_q  <= '0;
    end else if (clear) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      acc_q  <= '0;
    end else begin
      v1_q   <= valid;
      env1_q <= env;
      en1_q  <= en;
      v2_q   <= v1_q;
      v3_q   <= v2_q;
      if (v1_q) begin
        q_q    <= sram_q;
        env2_q <= env1_q;
        en2_q  <= en1_q;
      end
      if (v2_q) begin
        prod_q <= en2_q ? prod_c : '0;
      end
      if (v3_q) begin
        acc_q <= acc_c;
      end
    end
  end

endmodule

// File: rtl/wts_channel_mixer.sv
// Frame sequencer: snapshots channel state, reads one sample per channel, publishes the mix.
module wts_channel_mixer
  import wts_pkg::*;
#(
  parameter int unsigned CHANNELS = 5
) (
  input  logic                              nreset,
  input  logic                              clk,
  input  logic                              active,
  input  logic [WTS_ADDR_W*CHANNELS-1:0]    ch_sram_a,
  input  logic [WTS_ENV_W*CHANNELS-1:0]     ch_envelope,
  input  logic [CHANNELS-1:0]               ch_enable,
  output logic [WTS_SLOT_W+WTS_ADDR_W-1:0]  sram_a,
  output logic                              sram_oe,
  input  logic signed [WTS_SAMPLE_W-1:0]    sram_q,
  output logic signed [WTS_MIX_W-1:0]       sound_out,
  output logic                              sound_valid
);

  localparam int unsigned LAST_SLOT = CHANNELS - 1;

  wts_state_e                     state_q, state_c, state_n;
  logic [WTS_SLOT_W-1:0]          cnt_q, cnt_n;
  logic [WTS_ADDR_W*CHANNELS-1:0] snap_addr_q, addr_c;
  logic [WTS_ENV_W*CHANNELS-1:0]  snap_env_q;
  logic [CHANNELS-1:0]            snap_en_q;
  wts_sram_req_t                  req_q, req_c;
  logic                           oe_c, valid_c, clear_c;
  logic [WTS_ENV_W-1:0]           mac_env_c;
  logic                           mac_en_c;
  logic signed [WTS_MIX_W-1:0]    acc_c;

  // A frame-start pulse overrides the current state: that cycle is the snapshot cycle.
  always_comb begin
    state_c   = active ? ST_SNAP : state_q;
    state_n   = state_q;
    cnt_n     = cnt_q;
    clear_c   = 1'b0;
    addr_c    = (state_c == ST_SNAP) ? ch_sram_a : snap_addr_q;
    req_c     = '0;
    oe_c      = 1'b0;
    valid_c   = 1'b0;
    mac_env_c = snap_env_q[WTS_ENV_W*32'(req_q.slot) +: WTS_ENV_W];
    mac_en_c  = snap_en_q[32'(req_q.slot) +: 1];

    case (state_c)
      ST_IDLE: begin
        state_n = ST_IDLE;
      end
      ST_SNAP: begin
        clear_c = 1'b1;
        state_n = ST_READ;
        cnt_n   = '0;
      end
      ST_READ: begin
        if (cnt_q == WTS_SLOT_W'(LAST_SLOT)) begin
          state_n = ST_DRAIN;
          cnt_n   = '0;
        end else begin
          cnt_n   = cnt_q + WTS_SLOT_W'(1);
        end
      end
      ST_DRAIN: begin
        if (cnt_q == WTS_SLOT_W'(WTS_DRAIN_CYCLES - 1)) begin
          state_n = ST_DONE;
          cnt_n   = '0;
        end else begin
          cnt_n   = cnt_q + WTS_SLOT_W'(1);
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    if (state_n == ST_READ) begin
      oe_c       = 1'b1;
      req_c.slot = cnt_n;
      req_c.addr = addr_c[WTS_ADDR_W*32'(cnt_n) +: WTS_ADDR_W];
    end
    valid_c = (state_n == ST_DONE);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      snap_addr_q <= '0;
      snap_env_q  <= '0;
      snap_en_q   <= '0;
      req_q       <= '0;
      sram_oe     <= 1'b0;
      sound_out   <= '0;
      sound_valid <= 1'b0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      req_q       <= req_c;
      sram_oe     <= oe_c;
      sound_valid <= valid_c;
      if (state_c == ST_SNAP) begin
        snap_addr_q <= ch_sram_a;
        snap_env_q  <= ch_envelope;
        snap_en_q   <= ch_enable;
      end
      if (valid_c) begin
        sound_out <= acc_c;
      end
    end
  end

  assign sram_a = req_q;

  wts_channel_mac u_mac (
    .clk    (clk),
    .nreset (nreset),
    .clear  (clear_c),
    .valid  (sram_oe),
    .env    (mac_env_c),
    .en     (mac_en_c),
    .sram_q (sram_q),
    .acc_c  (acc_c)
  );

endmodule

// File: tb/tb_wts_channel_mixer.sv
// Directed-vector bench for wts_channel_mixer with a behavioural wave SRAM.
module tb_wts_channel_mixer;

  localparam int unsigned CH = 5;

  logic                 clk = 1'b0;
  logic                 nreset;
  logic                 active;
  logic [7*CH-1:0]      ch_sram_a;
  logic [9*CH-1:0]      ch_envelope;
  logic [CH-1:0]        ch_enable;
  logic [9:0]           sram_a;
  logic                 sram_oe;
  logic signed [7:0]    sram_q;
  logic signed [13:0]   sound_out;
  logic                 sound_valid;

  logic [7:0]           mem [1024];
  int                   errors = 0;
  int                   checks = 0;
  int                   last_out = 0;

  wts_channel_mixer #(.CHANNELS(CH)) dut (
    .nreset      (nreset),
    .clk         (clk),
    .active      (active),
    .ch_sram_a   (ch_sram_a),
    .ch_envelope (ch_envelope),
    .ch_enable   (ch_enable),
    .sram_a      (sram_a),
    .sram_oe     (sram_oe),
    .sram_q      (sram_q),
    .sound_out   (sound_out),
    .sound_valid (sound_valid)
  );

  always #5 clk = ~clk;

  // Synchronous-read SRAM: data appears the cycle after the strobe.
  always @(posedge clk) begin
    sram_q <= sram_oe ? $signed(mem[sram_a]) : 8'sd0;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int k, input logic [8:0] env, input logic [7:0] q);
    logic [6:0] a;
    a = 7'(7'h12 + 9 * k);
    ch_sram_a[7*k +: 7]   = a;
    ch_envelope[9*k +: 9] = env;
    mem[{3'(k), a}]       = q;
  endtask

  task automatic set_all(input logic [8:0] env, input logic [7:0] q);
    for (int k = 0; k < int'(CH); k++) set_ch(k, env, q);
  endtask

  // Runs one frame from an active pulse; optional mid-frame envelope change or second active.
  task automatic run_frame(input string tag, input int exp_out, input int exp_vcyc,
                           input int abort_cyc, input int mod_cyc, input logic [9*CH-1:0] mod_env);
    logic [9:0] exp_a [CH];
    int vcnt, vfirst, oecnt;
    for (int k = 0; k < int'(CH); k++) exp_a[k] = {3'(k), ch_sram_a[7*k +: 7]};
    vcnt = 0; vfirst = -1; oecnt = 0;
    @(posedge clk); #1 active = 1'b1;
    @(posedge clk); #1 active = 1'b0;
    for (int c = 1; c <= exp_vcyc + 3; c++) begin
      if (c == mod_cyc) ch_envelope = mod_env;
      active = (c == abort_cyc);
      if (sram_oe) oecnt++;
      if (abort_cyc == 0 && c <= int'(CH))
        chk($sformatf("%s sram_a slot%0d", tag, c - 1), int'(sram_a), int'(exp_a[c-1]));
      if (sound_valid && vfirst < 0) vfirst = c;
      if (sound_valid) vcnt++;
      if (c == exp_vcyc - 1) chk({tag, " hold"}, int'(sound_out), last_out);
      if (c == exp_vcyc)     chk({tag, " out"}, int'(sound_out), exp_out);
      @(posedge clk); #1;
    end
    active = 1'b0;
    chk({tag, " valid_count"}, vcnt, 1);
    chk({tag, " valid_cycle"}, vfirst, exp_vcyc);
    if (abort_cyc == 0) chk({tag, " oe_cycles"}, oecnt, int'(CH));
    last_out = exp_out;
  endtask

  initial begin
    logic [9*CH-1:0] env_v;
    int vcnt, oecnt;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    nreset = 1'b0; active = 1'b0;
    ch_sram_a = '0; ch_envelope = '0; ch_enable = '0;
    set_all(9'd0, 8'h11);
    repeat (3) @(posedge clk);
    #1 nreset = 1'b1;
    @(posedge clk); #1;
    chk("reset sram_a", int'(sram_a), 0);
    chk("reset sram_oe", int'(sram_oe), 0);
    chk("reset sound_out", int'(sound_out), 0);
    chk("reset sound_valid", int'(sound_valid), 0);

    // Only ch0: 0x40 at unity gain.
    set_ch(0, 9'd256, 8'h40); ch_enable = 5'b00001;
    run_frame("basic", 64, 9, 0, 0, '0);

    // Half envelope on -128.
    set_ch(0, 9'd128, 8'h80);
    run_frame("half_neg", -64, 9, 0, 0, '0);

    // -128 + 127 at unity.
    set_ch(0, 9'd256, 8'h80); set_ch(1, 9'd256, 8'h7f); ch_enable = 5'b00011;
    run_frame("neg_plus_pos", -1, 9, 0, 0, '0);

    // Full-scale sums.
    set_all(9'd511, 8'h7f); ch_enable = 5'b11111;
    run_frame("full_pos", 1265, 9, 0, 0, '0);
    set_all(9'd511, 8'h80);
    run_frame("full_neg", -1280, 9, 0, 0, '0);

    // Enable mask: only ch2 contributes, reads still issued for all.
    set_all(9'd256, 8'h20); ch_enable = 5'b00100;
    run_frame("enable_mask", 32, 9, 0, 0, '0);

    // Snapshot isolation: ch0 envelope drops to 0 in c2.
    set_all(9'd256, 8'h20); set_ch(0, 9'd256, 8'h40); ch_enable = 5'b00001;
    env_v = ch_envelope; env_v[8:0] = 9'd0;
    run_frame("snap_cur", 64, 9, 0, 2, env_v);
    run_frame("snap_next", 0, 9, 0, 0, '0);

    // Abort: second active in c4 restarts the frame.
    set_ch(0, 9'd256, 8'h40);
    run_frame("abort", 64, 13, 4, 0, '0);

    // Reset pulse in c3 of a frame.
    set_all(9'd256, 8'h20); ch_enable = 5'b11111;
    @(posedge clk); #1 active = 1'b1;
    @(posedge clk); #1 active = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    nreset = 1'b0; #1;
    chk("midreset sram_a", int'(sram_a), 0);
    chk("midreset sram_oe", int'(sram_oe), 0);
    chk("midreset sound_out", int'(sound_out), 0);
    chk("midreset sound_valid", int'(sound_valid), 0);
    @(posedge clk); #1 nreset = 1'b1;
    vcnt = 0; oecnt = 0;
    for (int c = 0; c < 14; c++) begin
      if (sound_valid) vcnt++;
      if (sram_oe) oecnt++;
      @(posedge clk); #1;
    end
    chk("postreset valid_count", vcnt, 0);
    chk("postreset oe_count", oecnt, 0);
    chk("postreset sound_out", int'(sound_out), 0);
    last_out = 0;

    // Recovery frame after reset: 5 x 32.
    run_frame("recover", 160, 9, 0, 0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
